// File: rtl/imem_loader_if.sv
// Stream-in / memory-write bundle for the boot loader.
// slave = loader side, master = the side that drives bytes and watches writes.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: takes a framed byte stream (LEN_LO, LEN_HI,
// 4*N little-endian data bytes, XOR checksum), writes each assembled word
// into instruction memory and releases the core only after a clean load.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [7:0]            chk_q, chk_d;
  logic [31:0]           asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  rx_ready;
  logic                  xfer;
  logic [15:0]           len_full;
  logic [16:0]           cap;
  logic [15:0]           words_after;

  // Byte acceptance is purely a function of the registered state.
  assign rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer        = bus.rx_valid && rx_ready;
  assign len_full    = {bus.rx_data, len_q[7:0]};
  assign cap         = 17'd1 << ADDR_WIDTH;
  // Words written once the current one goes out; compared against N to find the last word.
  assign words_after = 16'(word_idx_q) + 16'd1;

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

  // Next-state and registered-output computation; the strobe defaults low every cycle.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    chk_d      = chk_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          hold_d     = 1'b1;
          byte_idx_d = '0;
          word_idx_d = '0;
          chk_d      = '0;
          len_d      = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          // A zero or oversized program is rejected before any write.
          if ((len_full == 16'd0) || ({1'b0, len_full} > cap)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // New byte enters at the top so the first byte lands in [7:0] after four shifts.
          asm_d      = {bus.rx_data, asm_q[31:8]};
          chk_d      = chk_q ^ bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q[ADDR_WIDTH-1:0];
            wdata_d    = {bus.rx_data, asm_q[31:8]};
            word_idx_d = word_idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (words_after == len_q)
              state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (bus.rx_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset parks the core in hold and kills any pending write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      chk_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      chk_q      <= chk_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, length limits,
// stalls with stray start pulses, and reset in the middle of a load.
module tb_imem_loader;
  localparam int AW = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Write monitor: logs every strobe and the longest run of consecutive strobe cycles.
  logic [AW-1:0] wr_addr [0:1023];
  logic [31:0]   wr_data [0:1023];
  int nwr = 0;
  int run = 0;
  int max_run = 0;
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr[nwr] = bus.imem_addr;
      wr_data[nwr] = bus.imem_wdata;
      nwr = nwr + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; offers a byte until accepted (bounded) and returns at a negedge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (bus.rx_ready !== 1'b1) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  // Same as send, but with a random idle gap first and an optional stray start pulse in it.
  task automatic send_gap(input logic [7:0] b, input bit pulse);
    int g;
    g = $urandom_range(0, 3);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < g; i++) begin
      start = pulse && (i == 0);
      @(negedge clock);
    end
    start = 1'b0;
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  logic [7:0] good [0:10];
  int base;
  int errs;

  initial begin
    good = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // 1. reset state
    repeat (3) @(negedge clock);
    chk("rst_hold",  {31'd0, cpu_hold},     32'd1);
    chk("rst_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_we",    {31'd0, bus.imem_we},  32'd0);
    chk("rst_busy",  {31'd0, busy},         32'd0);
    chk("rst_done",  {31'd0, done},         32'd0);
    chk("rst_error", {31'd0, error},        32'd0);
    chk("rst_addr",  32'(bus.imem_addr),    32'd0);
    chk("rst_wdata", bus.imem_wdata,        32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 2. good load
    base = nwr;
    pulse_start();
    chk("start_busy",  {31'd0, busy},         32'd1);
    chk("start_ready", {31'd0, bus.rx_ready}, 32'd1);
    for (int i = 0; i < 11; i++) send(good[i]);
    chk("g_nwr",   nwr - base, 32'd2);
    chk("g_a0",    32'(wr_addr[base]),   32'd0);
    chk("g_d0",    wr_data[base],        32'h12345678);
    chk("g_a1",    32'(wr_addr[base+1]), 32'd1);
    chk("g_d1",    wr_data[base+1],      32'hDEADBEEF);
    chk("g_run",   max_run,              32'd1);
    chk("g_done",  {31'd0, done},        32'd1);
    chk("g_hold",  {31'd0, cpu_hold},    32'd0);
    chk("g_busy",  {31'd0, busy},        32'd0);
    chk("g_error", {31'd0, error},       32'd0);
    chk("g_hold_addr",  32'(bus.imem_addr), 32'd1);
    chk("g_hold_wdata", bus.imem_wdata,     32'hDEADBEEF);

    // bytes offered in DONE are not consumed
    bus.rx_data = 8'h55; bus.rx_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("done_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("done_stay",  {31'd0, done},         32'd1);
    bus.rx_valid = 1'b0;

    // 3. bad checksum
    base = nwr;
    pulse_start();
    for (int i = 0; i < 10; i++) send(good[i]);
    send(8'h2B);
    chk("b_nwr",   nwr - base,           32'd2);
    chk("b_d1",    wr_data[base+1],      32'hDEADBEEF);
    chk("b_error", {31'd0, error},       32'd1);
    chk("b_done",  {31'd0, done},        32'd0);
    chk("b_hold",  {31'd0, cpu_hold},    32'd1);
    chk("b_busy",  {31'd0, busy},        32'd0);

    // 4a. zero length
    base = nwr;
    pulse_start();
    send(8'h00); send(8'h00);
    @(negedge clock);
    chk("l0_error", {31'd0, error}, 32'd1);
    chk("l0_nwr",   nwr - base,     32'd0);

    // 4b. one word too many
    base = nwr;
    pulse_start();
    send(8'h41); send(8'h00);
    @(negedge clock);
    chk("l65_error", {31'd0, error},        32'd1);
    chk("l65_nwr",   nwr - base,            32'd0);
    chk("l65_ready", {31'd0, bus.rx_ready}, 32'd0);

    // 4c. full capacity: bytes 0..255, XOR of which is 0
    base = nwr;
    pulse_start();
    send(8'h40); send(8'h00);
    for (int k = 0; k < 256; k++) send(8'(k));
    send(8'h00);
    chk("l64_nwr", nwr - base, 32'd64);
    errs = 0;
    for (int w = 0; w < 64; w++) begin
      if (wr_addr[base+w] !== AW'(w)) errs++;
      if (wr_data[base+w] !== {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}) errs++;
    end
    chk("l64_content", errs,           32'd0);
    chk("l64_done",    {31'd0, done},  32'd1);

    // 5. random gaps and stray start pulses during DATA
    base = nwr;
    pulse_start();
    for (int i = 0; i < 11; i++) send_gap(good[i], (i >= 3 && i <= 8));
    chk("s_nwr",  nwr - base,           32'd2);
    chk("s_d0",   wr_data[base],        32'h12345678);
    chk("s_a1",   32'(wr_addr[base+1]), 32'd1);
    chk("s_d1",   wr_data[base+1],      32'hDEADBEEF);
    chk("s_done", {31'd0, done},        32'd1);
    chk("s_hold", {31'd0, cpu_hold},    32'd0);

    // 6. reset in the middle of the second word
    base = nwr;
    pulse_start();
    for (int i = 0; i < 8; i++) send(good[i]);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("r_nwr",   nwr - base,             32'd1);
    chk("r_a0",    32'(wr_addr[base]),     32'd0);
    chk("r_hold",  {31'd0, cpu_hold},      32'd1);
    chk("r_busy",  {31'd0, busy},          32'd0);
    chk("r_ready", {31'd0, bus.rx_ready},  32'd0);
    chk("r_addr",  32'(bus.imem_addr),     32'd0);
    base = nwr;
    pulse_start();
    for (int i = 0; i < 11; i++) send(good[i]);
    chk("r2_nwr",  nwr - base,        32'd2);
    chk("r2_done", {31'd0, done},     32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
